// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes, input int num_lines);
        return addr_w - off_w(line_bytes) - idx_w(num_lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous line or word write.
module dcache_sram #(
    parameter int LINE_W    = 256,
    parameter int DATA_W    = 32,
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5,
    parameter int TAG_W     = 22,
    parameter int WSEL_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [LINE_W-1:0] line_data_i,
    input  logic              word_we_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [DATA_W-1:0] word_data_i
);
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    assign rd_valid_o = r_valid[idx_i];
    assign rd_dirty_o = r_dirty[idx_i];
    assign rd_tag_o   = r_tag[idx_i];
    assign rd_line_o  = r_data[idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (line_we_i) begin
            r_valid[idx_i] <= 1'b1;
            r_dirty[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            r_dirty[idx_i] <= 1'b1;
        end
    end

    // Payload arrays are not reset; the valid bits make stale contents unreachable.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (line_we_i) begin
                r_tag[idx_i]  <= line_tag_i;
                r_data[idx_i] <= line_data_i;
            end else if (word_we_i) begin
                r_data[idx_i][word_sel_i*DATA_W +: DATA_W] <= word_data_i;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with pipeline stall.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
//
// state        | meaning
// ST_IDLE      | serve hits; a miss raises stall and picks writeback or refill
// ST_WRITEBACK | dirty victim line being written to memory
// ST_REFILL    | requested line being read from memory
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int NUM_LINES  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    p1_req_i,
    input  logic                    p1_we_i,
    input  logic [ADDR_W-1:0]       p1_addr_i,
    input  logic [DATA_W-1:0]       p1_wdata_i,
    output logic [DATA_W-1:0]       p1_rdata_o,
    output logic                    p1_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_wdata_o,
    input  logic [LINE_BYTES*8-1:0] mem_rdata_i,
    input  logic                    mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
`endif
);
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, NUM_LINES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BSEL_W = $clog2(DATA_W / 8);
    localparam int WORDS  = LINE_W / DATA_W;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e r_state;
    state_e w_next;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WSEL_W-1:0] w_wsel;
    logic              w_valid, w_dirty;
    logic [TAG_W-1:0]  w_vtag;
    logic [LINE_W-1:0] w_line;
    logic              w_hit, w_miss, w_line_we, w_word_we;
    logic              w_unused_addr;

    assign w_idx         = p1_addr_i[OFF_W +: IDX_W];
    assign w_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_wsel        = (WORDS > 1) ? p1_addr_i[BSEL_W +: WSEL_W] : '0;
    assign w_unused_addr = ^p1_addr_i[BSEL_W-1:0];

    dcache_sram #(
        .LINE_W    (LINE_W),
        .DATA_W    (DATA_W),
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .WSEL_W    (WSEL_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (w_idx),
        .rd_valid_o  (w_valid),
        .rd_dirty_o  (w_dirty),
        .rd_tag_o    (w_vtag),
        .rd_line_o   (w_line),
        .line_we_i   (w_line_we),
        .line_tag_i  (w_tag),
        .line_data_i (mem_rdata_i),
        .word_we_i   (w_word_we),
        .word_sel_i  (w_wsel),
        .word_data_i (p1_wdata_i)
    );

    assign w_hit     = (r_state == ST_IDLE) && p1_req_i && w_valid && (w_vtag == w_tag);
    assign w_miss    = (r_state == ST_IDLE) && p1_req_i && !(w_valid && (w_vtag == w_tag));
    assign w_line_we = (r_state == ST_REFILL) && mem_ack_i && !rst_i;
    assign w_word_we = w_hit && p1_we_i && !rst_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_miss) w_next = (w_valid && w_dirty) ? ST_WRITEBACK : ST_REFILL;
            ST_WRITEBACK: if (mem_ack_i) w_next = ST_REFILL;
            ST_REFILL:    if (mem_ack_i) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Memory-side outputs derive only from state and the stall-frozen CPU address,
    // so they are stable for the whole request.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            ST_WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {w_vtag, w_idx, {OFF_W{1'b0}}};
                mem_wdata_o = w_line;
            end
            ST_REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {w_tag, w_idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    assign p1_stall_o = (r_state != ST_IDLE) || w_miss;
    assign p1_rdata_o = (w_hit && !p1_we_i) ? w_line[w_wsel*DATA_W +: DATA_W] : '0;

`ifdef DCACHE_STATS_EN
    logic r_refilled;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_refilled <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            r_refilled <= (r_state == ST_REFILL) && mem_ack_i;
            if (w_hit && !r_refilled && (hit_cnt_o != 32'hFFFF_FFFF))
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (w_miss && (miss_cnt_o != 32'hFFFF_FFFF))
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl with a small line-memory model.
module tb_dcache_ctrl;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              p1_req, p1_we;
    logic [31:0]       p1_addr, p1_wdata, p1_rdata;
    logic              p1_stall;
    logic              mem_req, mem_we, mem_ack;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]       hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p1_req_i    (p1_req),
        .p1_we_i     (p1_we),
        .p1_addr_i   (p1_addr),
        .p1_wdata_i  (p1_wdata),
        .p1_rdata_o  (p1_rdata),
        .p1_stall_o  (p1_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        miss;
        logic        wb;
        logic [31:0] wb_addr;
        int          wb_word;
        logic [31:0] wb_val;
        int          wb_dly;
        logic [31:0] rf_addr;
        int          rf_dly;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];
    vec_t v_extra;
    logic [LINE_W-1:0] mem_model [logic [31:0]];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [LINE_W-1:0] pattern(input logic [31:0] a);
        logic [LINE_W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'hC000_0000 | (a + 32'(k * 4));
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] get_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pattern(a);
    endfunction

    // Entered at the negedge of the first cycle of a memory request; ack is
    // sampled at the dly-th rising edge of the request.
    task automatic wait_ack(input int dly, input logic [LINE_W-1:0] rd, output logic stable);
        logic              s_req, s_we, s_stall;
        logic [31:0]       s_addr;
        logic [LINE_W-1:0] s_wdata;
        s_req = mem_req; s_we = mem_we; s_stall = p1_stall; s_addr = mem_addr; s_wdata = mem_wdata;
        stable = 1'b1;
        for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            if (mem_req !== s_req || mem_we !== s_we || p1_stall !== s_stall ||
                mem_addr !== s_addr || mem_wdata !== s_wdata) stable = 1'b0;
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        logic st;
        @(posedge clk);
        #1;
        p1_req = 1'b1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata;
        @(negedge clk);
        check("stall_first", p1_stall, v.miss);
        if (v.miss) begin
            @(negedge clk);
            if (v.wb) begin
                check("wb_req", mem_req, 1'b1);
                check("wb_we", mem_we, 1'b1);
                check("wb_addr", mem_addr, v.wb_addr);
                check("wb_word", mem_wdata[v.wb_word*32 +: 32], v.wb_val);
                mem_model[mem_addr] = mem_wdata;
                wait_ack(v.wb_dly, '0, st);
                check("wb_hold", st, 1'b1);
                @(negedge clk);
            end
            check("rf_req", mem_req, 1'b1);
            check("rf_we", mem_we, 1'b0);
            check("rf_addr", mem_addr, v.rf_addr);
            check("rf_stall", p1_stall, 1'b1);
            wait_ack(v.rf_dly, get_line(v.rf_addr), st);
            check("rf_hold", st, 1'b1);
            @(negedge clk);
            check("stall_after", p1_stall, 1'b0);
        end
        check("rdata", p1_rdata, v.rdata);
        @(posedge clk);
        #1;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LINE_W-1:0] l40;
        //          we  addr      wdata         miss wb  wb_addr  wd wb_val        wdl rf_addr   rdl rdata
        vecs[0] = '{0, 32'h040, 32'h0,         1, 0, 32'h0,   0, 32'h0,         0, 32'h040, 3,  32'hC000_0040};
        vecs[1] = '{0, 32'h044, 32'h0,         0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0,  32'h1111_1111};
        vecs[2] = '{1, 32'h048, 32'hDEAD_BEEF, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0,  32'h0};
        vecs[3] = '{0, 32'h448, 32'h0,         1, 1, 32'h040, 2, 32'hDEAD_BEEF, 2, 32'h440, 1,  32'hC000_0448};
        vecs[4] = '{1, 32'h080, 32'hCAFE_F00D, 1, 0, 32'h0,   0, 32'h0,         0, 32'h080, 2,  32'h0};
        vecs[5] = '{0, 32'h080, 32'h0,         0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0,  32'hCAFE_F00D};
        vecs[6] = '{0, 32'h480, 32'h0,         1, 1, 32'h080, 0, 32'hCAFE_F00D, 1, 32'h480, 2,  32'hC000_0480};
        vecs[7] = '{0, 32'h048, 32'h0,         1, 0, 32'h0,   0, 32'h0,         0, 32'h040, 1,  32'hDEAD_BEEF};
        vecs[8] = '{0, 32'h04C, 32'h0,         0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0,  32'hC000_004C};
        vecs[9] = '{0, 32'h100, 32'h0,         1, 0, 32'h0,   0, 32'h0,         0, 32'h100, 10, 32'hC000_0100};

        l40 = pattern(32'h40);
        l40[32 +: 32] = 32'h1111_1111;
        mem_model[32'h40] = l40;

        rst = 1'b1; p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", p1_stall, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_rdata", p1_rdata, 32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Stray ack while idle must not start anything or disturb cached data.
        @(posedge clk);
        #1 mem_ack = 1'b1; mem_rdata = '1;
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("stray_req", mem_req, 1'b0);
        check("stray_stall", p1_stall, 1'b0);
        v_extra = '{0, 32'h044, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h1111_1111};
        run_vec(v_extra);

        // Reset in the middle of a refill aborts it.
        @(posedge clk);
        #1 p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h200;
        @(negedge clk);
        check("abort_miss", p1_stall, 1'b1);
        @(negedge clk);
        check("abort_rf_req", mem_req, 1'b1);
        check("abort_rf_addr", mem_addr, 32'h200);
        rst = 1'b1; p1_req = 1'b0; p1_addr = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_req", mem_req, 1'b0);
        check("abort_stall", p1_stall, 1'b0);
        v_extra = '{0, 32'h040, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h040, 2, 32'hC000_0040};
        run_vec(v_extra);
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("stat_miss", miss_cnt, 32'd1);
        check("stat_hit", hit_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Parametrised, direct-mapped, write-back/write-allocate data cache placed between the pipeline's MEM stage and a line-wide, variable-latency data memory. It replaces the single-cycle data memory access. On a miss it raises a stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A multi-state FSM handles dirty-victim writeback and line refill.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, CPU word width in bits; must be 32 or 64.
- LINE_BYTES, 32, line size in bytes; power of 2, at least DATA_W/8.
- NUM_LINES, 32, number of lines; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- p1_req_i  in  1  CPU access valid (MemRead or MemWrite from EX/MEM).
- p1_we_i  in  1  1 = store, 0 = load.
- p1_addr_i  in  ADDR_W  byte address; word-aligned.
- p1_wdata_i  in  DATA_W  store data.
- p1_rdata_o  out  DATA_W  load data; valid when p1_stall_o=0.
- p1_stall_o  out  1  freeze pipeline.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  ADDR_W  line-aligned address.
- mem_wdata_o  out  LINE_BYTES*8  victim line data.
- mem_rdata_i  in  LINE_BYTES*8  refill line data.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - OFF = log2(LINE_BYTES); IDX = log2(NUM_LINES); TAG = ADDR_W - OFF - IDX.
  - Word select = addr[OFF-1 : log2(DATA_W/8)].
- Per line: valid, dirty, tag, data.
- States: IDLE, WRITEBACK, REFILL.
- IDLE:
  - Hit (p1_req_i, valid, tag match): p1_stall_o=0 in the same cycle. Loads return the word combinationally. Stores write the word and set dirty at the clock edge.
  - Miss: p1_stall_o=1 combinationally. Next state is WRITEBACK if the victim is valid and dirty, else REFILL.
  - p1_req_i=0: no action; p1_stall_o=0.
- WRITEBACK:
  - Drives mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, idx, 0}, mem_wdata_o=victim line.
  - On mem_ack_i, go to REFILL.
- REFILL:
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, idx, 0}.
  - On mem_ack_i, write the line from mem_rdata_i, valid=1, dirty=0, go to IDLE.
  - The following IDLE cycle re-evaluates as a hit and deasserts the stall. A pending store merges then and sets dirty.
- p1_stall_o=1 in WRITEBACK and REFILL.
- Miss latency = refill ack delay + 1 cycle (+ writeback ack delay if dirty).
- Handshake:
  - mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_req_o=1.
  - mem_req_o drops in the cycle after ack (state change at the ack edge).
  - mem_ack_i is ignored when mem_req_o=0.
  - The CPU inputs are held stable by the stall.
- Reset:
  - All valid and dirty bits cleared; state=IDLE.
  - mem_req_o=0, mem_we_o=0, p1_stall_o=0, mem_addr_o=0, mem_wdata_o=0, p1_rdata_o=0 (with p1_req_i=0).
  - Reset mid-operation aborts WRITEBACK/REFILL with no line update; a dirty victim is lost by definition.
- p1_rdata_o is 0 when the access is not a load hit.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Hits count IDLE hits, excluding the post-refill re-evaluation hit.
  - Misses count IDLE-to-miss transitions.
  - Counters saturate at 0xFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package dcache_pkg holds:
  - State enum (IDLE, WRITEBACK, REFILL).
  - Width-derivation functions for OFF/IDX/TAG from the parameters.
- Sub-module dcache_sram: tag/valid/dirty/data arrays.
  - Combinational read by index; synchronous write of full line or single word plus flags.
  - Synchronous clear of valid/dirty on rst_i.

Test Plan (defaults):
1. Reset, then load 0x0000_0040 → stall=1; REFILL mem_addr_o=0x40, mem_we_o=0; ack after 3 cycles with word1=0x1111_1111 → stall=0 one cycle after ack; no WRITEBACK.
2. Load 0x44 right after test 1 → hit; stall=0 in the same cycle; p1_rdata_o=0x1111_1111.
3. Store 0xDEAD_BEEF to 0x48 (hit, dirty), then load 0x448 (index 2, tag 1) → WRITEBACK mem_addr_o=0x40, mem_wdata_o word2=0xDEAD_BEEF; then REFILL mem_addr_o=0x440.
4. Store miss to 0x80 on a clean line → REFILL 0x80, then merge; a later evicting load to 0x480 writes back 0x80 carrying the stored word.
5. Hold mem_ack_i low for 10 cycles in REFILL → mem_req_o, mem_addr_o and stall stay constant; a stray ack while idle → ignored.
6. Assert rst_i mid-REFILL → next cycle mem_req_o=0, stall=0; load 0x40 misses again (DCACHE_STATS_EN: miss_cnt_o=1 after reset).
